// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants for the key-expansion block and its S-box stage.
//   KEY_W / WORD_W / BYTE_W : AES-128 key, word and byte widths
//   NUM_ROUNDS / LAST_IDX   : number of round keys after the cipher key (10)
//   RCON                    : round constants indexed by round number 1..10
//   state_t                 : key-expansion FSM states
//   rot_word()              : AES RotWord (left rotation by one byte)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int NUM_ROUNDS = 10;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // Entry 0 and 11..15 are never used for a real round; padding to 16 lets a
    // 4-bit round index address the table without a range check.
    localparam logic [BYTE_W-1:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// Combinational AES SubWord: applies the forward S-box to each byte of a word.
//   i_word [31:0] : input word
//   o_word [31:0] : byte-wise S-box substitution of i_word
// -----------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    localparam logic [BYTE_W-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128 key expansion producing one round key per handshake.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : request to expand key_in (accepted only while idle)
//   key_in    : 128-bit cipher key, word 0 in [127:96]
//   busy      : expansion in progress
//   rk_valid  : rk_out / rk_idx hold a round key
//   rk_ready  : consumer accepts the current round key
//   rk_idx    : round index 0..10 of rk_out
//   rk_out    : round key {w0,w1,w2,w3}
//   done      : pulses during the handshake of round key 10
// Optional feature (macro AES_KEY_EXPAND_STORE_EN):
//   rd_idx    : round-key store read index
//   rd_key    : stored round key for rd_idx, zero when rd_idx > 10
// -----------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             done
`ifdef AES_KEY_EXPAND_STORE_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
`endif
);

    state_t             r_state;
    logic               r_busy;
    logic               r_rk_valid;
    logic [3:0]         r_rk_idx;
    logic [KEY_W-1:0]   r_rk_out;

    logic               w_accept;
    logic               w_handshake;
    logic               w_advance;
    logic [3:0]         w_next_idx;
    logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
    logic [WORD_W-1:0]  w_sub;
    logic [WORD_W-1:0]  w_temp;
    logic [WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;
    logic [KEY_W-1:0]   w_next_key;

    // busy is low exactly in IDLE, so a start during RUN (including the final
    // handshake cycle) is dropped.
    assign w_accept    = (r_state == S_IDLE) & start;
    assign w_handshake = r_rk_valid & rk_ready;
    assign w_advance   = (r_state == S_RUN) & w_handshake & (r_rk_idx != LAST_IDX);
    assign w_next_idx  = r_rk_idx + 4'd1;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk_out;

    aes_sub_word u_sub_word (
        .i_word (rot_word(w_w3)),
        .o_word (w_sub)
    );

    assign w_temp     = w_sub ^ {RCON[w_next_idx], 24'h0};
    assign w_n0       = w_w0 ^ w_temp;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_idx   <= '0;
            r_rk_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_rk_valid <= 1'b1;
                        r_rk_idx   <= '0;
                        r_rk_out   <= key_in;
                    end
                end
                S_RUN: begin
                    if (w_handshake) begin
                        if (r_rk_idx == LAST_IDX) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_rk_valid <= 1'b0;
                        end else begin
                            r_rk_idx <= w_next_idx;
                            r_rk_out <= w_next_key;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk_out   = r_rk_out;
    // done must coincide with the final handshake, so it is decoded from the
    // live rk_ready rather than registered.
    assign done     = w_handshake & (r_rk_idx == LAST_IDX);

`ifdef AES_KEY_EXPAND_STORE_EN
    logic [KEY_W-1:0] r_store [0:NUM_ROUNDS];

    // NOTE: the store is explicitly reset entry by entry because a cleared
    // store is observable through rd_key; most memories would not be reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_accept) begin
            r_store[0] <= key_in;
        end else if (w_advance) begin
            r_store[w_next_idx] <= w_next_key;
        end
    end

    assign rd_key = (rd_idx <= LAST_IDX) ? r_store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
// Scoreboard bench for aes_key_expand: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every rk_valid & rk_ready handshake.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           check_key;
    } exp_t;

    localparam logic [127:0] KEY_A     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_IDX1 = 128'h62636363626363636263636362636363;

    logic [127:0] rk_a [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         done;
`ifdef AES_KEY_EXPAND_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_start = 0;
    bit   lat_armed = 0;

    aes_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out),
        .done     (done)
`ifdef AES_KEY_EXPAND_STORE_EN
        ,
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected sequence for one expansion; the all-zero key has a published
    // value only for round 1, so later rounds check the index alone.
    task automatic push_expected(input bit zero_key);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            if (zero_key) begin
                e.key       = (i == 1) ? ZERO_IDX1 : '0;
                e.check_key = (i <= 1);
            end else begin
                e.key       = rk_a[i];
                e.check_key = 1'b1;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic issue_start(input bit zero_key);
        push_expected(zero_key);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = zero_key ? '0 : KEY_A;
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_idx(input logic [3:0] k);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rk_valid && rk_idx == k) return;
        end
        check($sformatf("timeout_idx%0d", k), 0, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("timeout_idle", 0, 1);
    endtask

    // Monitor: compare every accepted round key against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rk_valid && rk_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_key", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rk_idx", rk_idx, mon_e.idx);
                if (mon_e.check_key)
                    check($sformatf("rk_out[%0d]", mon_e.idx), rk_out, mon_e.key);
                check($sformatf("done@%0d", mon_e.idx), done, mon_e.idx == 4'd10);
                check("busy_run", busy, 1);
                if (mon_e.idx == 4'd10 && lat_armed) begin
                    check("latency", cyc - t_start, 10);
                    lat_armed = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
`ifdef AES_KEY_EXPAND_STORE_EN
        rd_idx   = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", rk_valid, 0);
        check("rst_done", done, 0);
        check("rst_idx", rk_idx, 0);
        check("rst_out", rk_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 key, constant rk_ready, latency start -> idx10.
        lat_armed = 1;
        issue_start(1'b0);
        wait_idle();
        check("idle_busy", busy, 0);
        check("idle_valid", rk_valid, 0);
        check("latency_seen", lat_armed, 0);
`ifdef AES_KEY_EXPAND_STORE_EN
        rd_idx = 4'd10; #1 check("store_rd10", rd_key, rk_a[10]);
        rd_idx = 4'd12; #1 check("store_rd12", rd_key, 0);
        rd_idx = 4'd0;  #1 check("store_rd0", rd_key, KEY_A);
`endif

        // All-zero key; start held during the final handshake must be dropped.
        issue_start(1'b1);
        wait_idx(4'd9);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = KEY_A;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("final_start_valid", rk_valid, 0);
        check("final_start_busy", busy, 0);
`ifdef AES_KEY_EXPAND_STORE_EN
        rd_idx = 4'd1; #1 check("store_overwrite", rd_key, ZERO_IDX1);
`endif

        // Back-pressure: rk_ready low for three cycles while idx 4 is shown.
        issue_start(1'b0);
        wait_idx(4'd3);
        @(posedge clk); #1;
        rk_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_idx", rk_idx, 4);
            check("stall_out", rk_out, rk_a[4]);
            check("stall_valid", rk_valid, 1);
            check("stall_done", done, 0);
            @(posedge clk); #1;
        end
        rk_ready = 1'b1;
        wait_idle();

        // start pulsed mid-run (idx 6) with a different key is ignored.
        issue_start(1'b0);
        wait_idx(4'd5);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Reset at idx 5, then start on the very first cycle after reset.
        issue_start(1'b0);
        wait_idx(4'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        push_expected(1'b0);
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_valid", rk_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_idx", rk_idx, 0);
        check("midrst_out", rk_out, 0);
`ifdef AES_KEY_EXPAND_STORE_EN
        rd_idx = 4'd10; #1 check("store_cleared", rd_key, 0);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
`ifdef AES_KEY_EXPAND_STORE_EN
        rd_idx = 4'd10; #1 check("store_rerun_rd10", rd_key, rk_a[10]);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameters: none; all sizes are fixed by AES-128 and held in the shared package.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  single-cycle request to begin expansion of key_in.
REQ-005 key_in  input  128  cipher key, sampled on the accepted start cycle; word 0 is [127:96].
REQ-006 busy  output  1  high from the cycle after an accepted start until the cycle after the last handshake.
REQ-007 rk_valid  output  1  rk_out and rk_idx hold a valid round key.
REQ-008 rk_ready  input  1  consumer accepts the round key this cycle.
REQ-009 rk_idx  output  4  round index 0..10 of rk_out.
REQ-010 rk_out  output  128  round key {w0,w1,w2,w3}.
REQ-011 done  output  1  one-cycle pulse on the handshake of rk_idx 10.

Function
REQ-012 The FSM SHALL have two states, IDLE and RUN.
REQ-013 IDLE: start accepted only when busy=0; start during RUN SHALL be ignored.
REQ-014 Accepted start at edge T SHALL load key_in, enter RUN, and assert rk_valid=1, rk_idx=0, rk_out=key_in, visible after edge T.
REQ-015 Handshake = rk_valid & rk_ready; rk_out and rk_idx SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-016 On handshake with rk_idx<10, the next edge SHALL load round key rk_idx+1, with rk_valid staying high, giving 1 key per cycle under constant rk_ready.
REQ-017 The next key SHALL be computed as temp = SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-018 RotWord SHALL be a left rotation by one byte.
REQ-019 Rcon for i=1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-020 Handshake with rk_idx=10 SHALL pulse done for that cycle; the next edge SHALL clear rk_valid and busy and return to IDLE.
REQ-021 Minimum latency SHALL be start at T -> rk_idx 10 valid after edge T+10; no bubbles while rk_ready=1.
REQ-022 start coincident with the final handshake SHALL be ignored; a new start is accepted from the first IDLE cycle.

Reset
REQ-023 rst high at an edge SHALL force IDLE, busy=0, rk_valid=0, done=0, rk_idx=0, rk_out=0, overriding start, handshake, and an expansion in progress.
REQ-024 After rst deasserts, the block SHALL accept start on the first cycle.

Configuration
REQ-025 With AES_KEY_EXPAND_STORE_EN defined, the block SHALL add input rd_idx[3:0] and output rd_key[127:0], storing each round key as it is loaded; rd_key SHALL read the store combinationally, and rd_idx>10 SHALL return 0.
REQ-026 With AES_KEY_EXPAND_STORE_EN defined, rst SHALL clear the store, and a new start SHALL overwrite it entry by entry.
REQ-027 Without AES_KEY_EXPAND_STORE_EN, the rd_idx/rd_key ports and the store SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 The shared package aes_pkg SHALL hold the Rcon table, NUM_ROUNDS=10, and the 128/32/8-bit width constants.
REQ-029 The block SHALL instantiate exactly one aes_sub_word for the SubWord step; no other sub-module.

Verification
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605; idx10 d014f9a8c9ee2589e13f0cc8b6630ca6; done with idx10 at T+10.
REQ-031 Key all-zero -> idx1 62636363626363636263636362636363.
REQ-032 rk_ready low 3 cycles at idx 4 -> rk_out and rk_idx stable, idx5 follows the handshake, final keys unchanged.
REQ-033 start pulsed during RUN at idx 6 -> ignored, sequence and final key unchanged.
REQ-034 rst at idx 5 -> all outputs 0 the next cycle; a fresh start then reproduces the REQ-030 sequence.
REQ-035 With STORE_EN, after REQ-030: rd_idx=10 -> d014…0ca6; rd_idx=12 -> 0.
